// File: rtl/axi_lite_pkg.sv
// Shared types, response codes, register offsets and the
// address decode used by both regfile read and write paths.
package axi_lite_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam logic [7:0] OFF_ID       = 8'h00;
  localparam logic [7:0] OFF_WR_CNT   = 8'h04;
  localparam logic [7:0] OFF_RD_CNT   = 8'h08;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h0C;
  localparam logic [7:0] OFF_IRQ_MASK = 8'h10;
  localparam logic [7:0] OFF_USER     = 8'h20;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ID,
    SEL_WR_CNT,
    SEL_RD_CNT,
    SEL_IRQ_STAT,
    SEL_IRQ_MASK,
    SEL_USER
  } sel_e;

  typedef struct packed {
    sel_e       sel;
    logic [4:0] uidx;
    logic       ro;
  } dec_t;

  typedef enum logic {
    W_IDLE,
    W_ACK
  } wstate_e;

  function automatic dec_t decode(
    input addr_t       a,
    input int unsigned nregs,
    input logic        irq_en
  );
    dec_t       d;
    logic [7:0] off;
    logic [7:0] ulim;
    d.sel  = SEL_NONE;
    d.uidx = '0;
    d.ro   = 1'b0;
    off    = a[7:0];
    ulim   = OFF_USER + 8'(nregs * 4);
    // Upper bits must be zero so e.g. 0x200 does not alias ID.
    if (a[31:8] == '0 && a[1:0] == 2'b00) begin
      unique case (1'b1)
        off == OFF_ID: begin
          d.sel = SEL_ID;
          d.ro  = 1'b1;
        end
        off == OFF_WR_CNT: begin
          d.sel = SEL_WR_CNT;
          d.ro  = 1'b1;
        end
        off == OFF_RD_CNT: begin
          d.sel = SEL_RD_CNT;
          d.ro  = 1'b1;
        end
        irq_en && off == OFF_IRQ_STAT:
          d.sel = SEL_IRQ_STAT;
        irq_en && off == OFF_IRQ_MASK:
          d.sel = SEL_IRQ_MASK;
        off >= OFF_USER && off < ulim: begin
          d.sel  = SEL_USER;
          d.uidx = 5'((off - OFF_USER) >> 2);
        end
        default: ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// Write-commit / read-strobe bus between the AXI-lite
// slave front end and the register bank.
interface axi_lite_regfile_if;
  import axi_lite_pkg::*;

  addr_t waddr;
  data_t wdata;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  addr_t raddr;
  logic  rd_en;
  data_t rdata;
  resp_t rresp;

  modport master (
    output waddr, wdata, wvalid,
    output raddr, rd_en,
    input  wready, bresp,
    input  rdata, rresp
  );

  modport slave (
    input  waddr, wdata, wvalid,
    input  raddr, rd_en,
    output wready, bresp,
    output rdata, rresp
  );
endinterface

// File: rtl/axi_regfile_irq.sv
// Sticky interrupt status (W1C, set wins), mask and
// registered irq output.
module axi_regfile_irq #(
  parameter int IRQ_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq_src,
  input  logic             stat_we,
  input  logic             mask_we,
  input  logic [IRQ_W-1:0] wdata,
  output logic [IRQ_W-1:0] stat,
  output logic [IRQ_W-1:0] mask,
  output logic             irq
);

  logic [IRQ_W-1:0] stat_q, stat_d;
  logic [IRQ_W-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  always_comb begin
    stat_d = stat_q;
    mask_d = mask_q;
    if (stat_we) stat_d = stat_q & ~wdata;
    stat_d = stat_d | irq_src;
    if (mask_we) mask_d = wdata;
    irq_d = |(stat_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign stat = stat_q;
  assign mask = mask_q;
  assign irq  = irq_q;

endmodule

// File: rtl/axi_lite_regfile.sv
// Register bank: ID, WR/RD counters, NUM_REGS user regs.
// IRQ stat/mask and irq port exist when AXI_REGFILE_IRQ_EN is defined.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001,
  parameter logic [31:0] USER_RST = 32'h0,
  parameter int          IRQ_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_lite_regfile_if.slave        bus,
  output logic [NUM_REGS*32-1:0]   user_q
`ifdef AXI_REGFILE_IRQ_EN
  ,
  input  logic [IRQ_W-1:0]         irq_src,
  output logic                     irq
`endif
);

`ifdef AXI_REGFILE_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  wstate_e state_q, state_d;
  resp_t   bresp_q, bresp_d;
  data_t   rdata_q, rdata_d;
  resp_t   rresp_q, rresp_d;
  data_t   wr_cnt_q, wr_cnt_d;
  data_t   rd_cnt_q, rd_cnt_d;
  data_t   usr_q [NUM_REGS];
  data_t   usr_d [NUM_REGS];

  dec_t    wdec;
  dec_t    rdec;
  logic    commit;
  logic    wok;
  data_t   rval;
  data_t   irq_stat_rd;
  data_t   irq_mask_rd;

  assign wdec   = decode(bus.waddr, NUM_REGS, IRQ_EN);
  assign rdec   = decode(bus.raddr, NUM_REGS, IRQ_EN);
  assign commit = (state_q == W_ACK);
  assign wok    = (wdec.sel != SEL_NONE) && !wdec.ro;

`ifdef AXI_REGFILE_IRQ_EN
  logic [IRQ_W-1:0] stat;
  logic [IRQ_W-1:0] mask;

  axi_regfile_irq #(
    .IRQ_W (IRQ_W)
  ) u_irq (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .stat_we (commit && wok && wdec.sel == SEL_IRQ_STAT),
    .mask_we (commit && wok && wdec.sel == SEL_IRQ_MASK),
    .wdata   (bus.wdata[IRQ_W-1:0]),
    .stat    (stat),
    .mask    (mask),
    .irq     (irq)
  );

  assign irq_stat_rd = {{(32-IRQ_W){1'b0}}, stat};
  assign irq_mask_rd = {{(32-IRQ_W){1'b0}}, mask};
`else
  assign irq_stat_rd = '0;
  assign irq_mask_rd = '0;
`endif

  always_comb begin
    rval = '0;
    unique case (rdec.sel)
      SEL_ID:       rval = ID_VALUE;
      SEL_WR_CNT:   rval = wr_cnt_q;
      SEL_RD_CNT:   rval = rd_cnt_q;
      SEL_IRQ_STAT: rval = irq_stat_rd;
      SEL_IRQ_MASK: rval = irq_mask_rd;
      SEL_USER: begin
        for (int i = 0; i < NUM_REGS; i++)
          if (rdec.uidx == 5'(i)) rval = usr_q[i];
      end
      default:      rval = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    bresp_d  = bresp_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    usr_d    = usr_q;

    unique case (state_q)
      W_IDLE:  if (bus.wvalid) state_d = W_ACK;
      W_ACK:   state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase

    // Commit happens on the edge leaving W_ACK.
    if (commit) begin
      bresp_d = wok ? RESP_OKAY : RESP_SLVERR;
      if (wok) wr_cnt_d = wr_cnt_q + 32'd1;
      if (wok && wdec.sel == SEL_USER) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (wdec.uidx == 5'(i)) usr_d[i] = bus.wdata;
      end
    end

    if (bus.rd_en) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
      rdata_d  = rval;
      rresp_d  = (rdec.sel == SEL_NONE) ? RESP_SLVERR
                                        : RESP_OKAY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= W_IDLE;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        usr_q[i] <= USER_RST;
    end else begin
      state_q  <= state_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      usr_q    <= usr_d;
    end
  end

  assign bus.wready = (state_q == W_ACK);
  assign bus.bresp  = bresp_q;
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_user
    assign user_q[g*32 +: 32] = usr_q[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed table-driven bench for axi_lite_regfile.
// Hand sequences cover RD_CNT, hold, collision, IRQ, reset.
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  logic         clk;
  logic         rst;
  logic [255:0] user_q;
`ifdef AXI_REGFILE_IRQ_EN
  logic [3:0]   irq_src;
  logic         irq;
`endif

  axi_lite_regfile_if bus ();

  axi_lite_regfile #(
    .NUM_REGS (8),
    .ID_VALUE (32'hA11E_0001),
    .USER_RST (32'h0),
    .IRQ_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .user_q  (user_q)
`ifdef AXI_REGFILE_IRQ_EN
    ,
    .irq_src (irq_src),
    .irq     (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic  wr;
    addr_t addr;
    data_t data;
    resp_t er;
    data_t ed;
    string nm;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_write(input addr_t a, input data_t d,
                          output resp_t r);
    int n;
    n = 0;
    @(negedge clk);
    bus.waddr  = a;
    bus.wdata  = d;
    bus.wvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wready && n < 4);
    chk("wready_latency", 32'(n), 32'd1);
    bus.wvalid = 1'b0;
    @(negedge clk);
    chk("wready_single", 32'(bus.wready), 32'd0);
    r = bus.bresp;
  endtask

  task automatic do_read(input addr_t a, output data_t d,
                         output resp_t r);
    @(negedge clk);
    bus.raddr = a;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rdata;
    r = bus.rresp;
  endtask

  initial begin
    data_t d;
    resp_t r;

    rst        = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.wvalid = 1'b0;
    bus.raddr  = '0;
    bus.rd_en  = 1'b0;
`ifdef AXI_REGFILE_IRQ_EN
    irq_src    = '0;
`endif

    tv.push_back('{0, 32'h00, 0, RESP_OKAY,   32'hA11E_0001, "rd_id"});
    tv.push_back('{1, 32'h24, 32'hDEAD_BEEF, RESP_OKAY, 0, "wr_u1"});
    tv.push_back('{0, 32'h24, 0, RESP_OKAY,   32'hDEAD_BEEF, "rd_u1"});
    tv.push_back('{0, 32'h04, 0, RESP_OKAY,   32'd1,         "wrcnt1"});
    tv.push_back('{1, 32'h04, 32'h1234, RESP_SLVERR, 0,      "wr_ro"});
    tv.push_back('{1, 32'h22, 32'h5555, RESP_SLVERR, 0,      "wr_mis"});
    tv.push_back('{1, 32'h200, 32'h6666, RESP_SLVERR, 0,     "wr_unm"});
    tv.push_back('{1, 32'h00, 32'h7777, RESP_SLVERR, 0,      "wr_id"});
    tv.push_back('{0, 32'h04, 0, RESP_OKAY,   32'd1,         "wrcnt_hold"});
    tv.push_back('{0, 32'h24, 0, RESP_OKAY,   32'hDEAD_BEEF, "rd_u1_b"});
    tv.push_back('{0, 32'h20, 0, RESP_OKAY,   32'h0,         "rd_u0"});
    tv.push_back('{0, 32'h300, 0, RESP_SLVERR, 32'h0,        "rd_unm"});
    tv.push_back('{0, 32'h26, 0, RESP_SLVERR, 32'h0,         "rd_mis"});
    tv.push_back('{1, 32'h3C, 32'h1234_5678, RESP_OKAY, 0,   "wr_u7"});
    tv.push_back('{0, 32'h3C, 0, RESP_OKAY,   32'h1234_5678, "rd_u7"});
    tv.push_back('{0, 32'h40, 0, RESP_SLVERR, 32'h0,         "rd_u8"});
    tv.push_back('{0, 32'h04, 0, RESP_OKAY,   32'd2,         "wrcnt2"});
`ifdef AXI_REGFILE_IRQ_EN
    tv.push_back('{0, 32'h10, 0, RESP_OKAY,   32'h0,         "rd_mask"});
    tv.push_back('{0, 32'h0C, 0, RESP_OKAY,   32'h0,         "rd_stat"});
`else
    tv.push_back('{0, 32'h0C, 0, RESP_SLVERR, 32'h0,         "rd_0c"});
    tv.push_back('{1, 32'h10, 32'h1, RESP_SLVERR, 0,         "wr_10"});
    tv.push_back('{0, 32'h10, 0, RESP_SLVERR, 32'h0,         "rd_10"});
`endif

    repeat (3) @(negedge clk);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bresp",  32'(bus.bresp),  32'(RESP_OKAY));
    chk("rst_rdata",  bus.rdata,       32'h0);
    chk("rst_rresp",  32'(bus.rresp),  32'(RESP_OKAY));
    chk("rst_user0",  user_q[31:0],    32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_wready", 32'(bus.wready), 32'd0);

    do_read(32'h08, d, r);
    chk("rdcnt_0", d, 32'd0);
    do_read(32'h08, d, r);
    chk("rdcnt_1", d, 32'd1);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].wr) begin
        do_write(tv[i].addr, tv[i].data, r);
        chk({tv[i].nm, "_bresp"}, 32'(r), 32'(tv[i].er));
      end else begin
        do_read(tv[i].addr, d, r);
        chk({tv[i].nm, "_rdata"}, d, tv[i].ed);
        chk({tv[i].nm, "_rresp"}, 32'(r), 32'(tv[i].er));
      end
    end

    chk("user_q_u1", user_q[63:32],   32'hDEAD_BEEF);
    chk("user_q_u7", user_q[255:224], 32'h1234_5678);
    chk("user_q_u0", user_q[31:0],    32'h0);

    // rdata holds across idle cycles and unrelated writes
    do_read(32'h24, d, r);
    repeat (3) @(negedge clk);
    do_write(32'h28, 32'h77, r);
    chk("hold_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("hold_rresp", 32'(bus.rresp), 32'(RESP_OKAY));

    // read and commit to the same register in one cycle
    @(negedge clk);
    bus.waddr  = 32'h20;
    bus.wdata  = 32'd5;
    bus.wvalid = 1'b1;
    @(negedge clk);
    chk("coll_wready", 32'(bus.wready), 32'd1);
    bus.wvalid = 1'b0;
    bus.raddr  = 32'h20;
    bus.rd_en  = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("coll_old", bus.rdata, 32'h0);
    chk("coll_bresp", 32'(bus.bresp), 32'(RESP_OKAY));
    do_read(32'h20, d, r);
    chk("coll_new", d, 32'd5);

`ifdef AXI_REGFILE_IRQ_EN
    do_write(32'h10, 32'h1, r);
    chk("irq_mask_bresp", 32'(r), 32'(RESP_OKAY));
    @(negedge clk);
    irq_src = 4'h1;
    @(negedge clk);
    irq_src = 4'h0;
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    do_read(32'h0C, d, r);
    chk("irq_stat1", d, 32'h1);
    irq_src = 4'h1;
    do_write(32'h0C, 32'h1, r);
    do_read(32'h0C, d, r);
    chk("irq_setwins", d, 32'h1);
    chk("irq_still", 32'(irq), 32'd1);
    irq_src = 4'h0;
    do_write(32'h0C, 32'h1, r);
    repeat (2) @(negedge clk);
    chk("irq_clr", 32'(irq), 32'd0);
    do_read(32'h0C, d, r);
    chk("irq_stat0", d, 32'h0);
`endif

    // reset while a commit is pending
    @(negedge clk);
    bus.waddr  = 32'h2C;
    bus.wdata  = 32'hAA;
    bus.wvalid = 1'b1;
    @(negedge clk);
    chk("mid_wready", 32'(bus.wready), 32'd1);
    rst        = 1'b0;
    bus.raddr  = 32'h24;
    bus.rd_en  = 1'b1;
    @(negedge clk);
    chk("mid_wready0", 32'(bus.wready), 32'd0);
    chk("mid_rdata",   bus.rdata, 32'h0);
    chk("mid_user",    user_q[63:32], 32'h0);
    bus.wvalid = 1'b0;
    bus.rd_en  = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("mid_user2", user_q[95:64], 32'h0);
    do_read(32'h08, d, r);
    chk("mid_rdcnt", d, 32'd0);
    do_read(32'h04, d, r);
    chk("mid_wrcnt", d, 32'd0);
    do_read(32'h2C, d, r);
    chk("mid_nocommit", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
